// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter with a two-state FSM.
// A grant is held until the holder releases, withdraws its request, or
// reaches the MAX_HOLD cycle limit. The grant is then dropped for at least
// one dead cycle, and the search pointer moves past the previous holder.
// Every output is registered.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req_i,
  input  logic       release_i,
  output logic [7:0] gnt_o,
  output logic [2:0] gnt_idx_o,
  output logic       gnt_valid_o,
  output logic       timeout_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Hold count at which the current grant is forced off. It is reached
  // after MAX_HOLD cycles in GRANT.
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

  state_t     state_q;
  logic [2:0] ptr_q;
  logic [7:0] hold_q;
  logic [7:0] gnt_q;
  logic [2:0] gnt_idx_q;
  logic       gnt_valid_q;
  logic       timeout_q;

  // Arbitration datapath
  logic [7:0] req_rot;
  logic [2:0] pick_off;
  logic [2:0] pick_idx;
  logic [7:0] pick_onehot;

  // GRANT exit causes
  logic       exit_release;
  logic       exit_withdraw;
  logic       exit_limit;
  logic       exit_any;

  // Rotate the request vector so that bit 0 is the requester at ptr.
  // The 3-bit sum wraps modulo 8 on its own.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_rot
      assign req_rot[gi] = req_i[3'(ptr_q + 3'(gi))];
    end
  endgenerate

  // Find the first set bit of the rotated vector; offset 0 means ptr itself.
  always_comb begin
    logic found;
    found    = 1'b0;
    pick_off = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!found && req_rot[i]) begin
        found    = 1'b1;
        pick_off = 3'(i);
      end
    end
  end

  assign pick_idx = ptr_q + pick_off;

  // One-hot decode of the chosen index.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_dec
      assign pick_onehot[gi] = (pick_idx == 3'(gi));
    end
  endgenerate

  assign exit_release  = release_i;
  assign exit_withdraw = ~req_i[gnt_idx_q];
  assign exit_limit    = (hold_q == HOLD_LIMIT);
  assign exit_any      = exit_release | exit_withdraw | exit_limit;

  // Arbiter FSM. It updates state, pointer, hold counter and all
  // registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 3'd0;
      hold_q      <= 8'd0;
      gnt_q       <= 8'h00;
      gnt_idx_q   <= 3'd0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      // timeout is a single-cycle pulse unless the exit branch below sets it.
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req_i) begin
            state_q     <= GRANT;
            gnt_q       <= pick_onehot;
            gnt_idx_q   <= pick_idx;
            gnt_valid_q <= 1'b1;
            hold_q      <= 8'd0;
          end
        end
        GRANT: begin
          if (exit_any) begin
            // gnt_idx keeps the last holder. The pointer moves just past it.
            state_q     <= IDLE;
            ptr_q       <= gnt_idx_q + 3'd1;
            gnt_q       <= 8'h00;
            gnt_valid_q <= 1'b0;
            hold_q      <= 8'd0;
            // An exit counts as a timeout only when the hold limit is the
            // sole cause.
            timeout_q   <= exit_limit & ~exit_release & ~exit_withdraw;
          end else begin
            // Requests from other requesters are ignored while a grant is held.
            hold_q <= hold_q + 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = gnt_idx_q;
  assign gnt_valid_o = gnt_valid_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed checks of rr_arbiter8 with MAX_HOLD=4.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       rel;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int tests = 0;
  int fails = 0;

  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .release_i   (rel),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid),
    .timeout_o   (timeout)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then wait 1 time unit so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] e_gnt, input logic [2:0] e_idx,
                         input logic e_val, input logic e_to);
    chk({tag, ".gnt"}, gnt, e_gnt);
    chk({tag, ".idx"}, {5'd0, gnt_idx}, {5'd0, e_idx});
    chk({tag, ".valid"}, {7'd0, gnt_valid}, {7'd0, e_val});
    chk({tag, ".timeout"}, {7'd0, timeout}, {7'd0, e_to});
    $display("[TB] %s req=%02h rel=%0b -> gnt=%02h idx=%0d valid=%0b timeout=%0b",
             tag, req, rel, gnt, gnt_idx, gnt_valid, timeout);
  endtask

  initial begin
    rst = 1'b1; req = 8'h00; rel = 1'b0;
    step(); step();
    chk_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // Single requester 4 releases after three grant cycles.
    req = 8'b0001_0000;
    step(); chk_out("r4.c1", 8'h10, 3'd4, 1'b1, 1'b0);
    step(); chk_out("r4.c2", 8'h10, 3'd4, 1'b1, 1'b0);
    step(); chk_out("r4.c3", 8'h10, 3'd4, 1'b1, 1'b0);
    rel = 1'b1;
    step(); chk_out("r4.dead", 8'h00, 3'd4, 1'b0, 1'b0);
    rel = 1'b0;
    // ptr is now 5: bits 0, 4 and 5 are set, so 5 wins.
    req = 8'b0011_0001;
    step(); chk_out("ptr5", 8'h20, 3'd5, 1'b1, 1'b0);
    rel = 1'b1;
    step(); chk_out("r5.exit", 8'h00, 3'd5, 1'b0, 1'b0);
    rel = 1'b0; req = 8'h00;
    step(); chk_out("idle.hold_idx", 8'h00, 3'd5, 1'b0, 1'b0);

    // All requesters with release every grant: full rotation 0..7, then 0.
    rst = 1'b1; step(); rst = 1'b0;
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      step();
      chk_out($sformatf("rot%0d", i), 8'(1 << (i % 8)), 3'(i % 8), 1'b1, 1'b0);
      rel = 1'b1;
      step();
      chk_out($sformatf("rot%0d.dead", i), 8'h00, 3'(i % 8), 1'b0, 1'b0);
      rel = 1'b0;
    end

    // Hold limit of 4 on requester 7 produces a timeout, then 7 is granted again.
    rst = 1'b1; step(); rst = 1'b0;
    req = 8'h80;
    step(); chk_out("to.c1", 8'h80, 3'd7, 1'b1, 1'b0);
    step(); chk_out("to.c2", 8'h80, 3'd7, 1'b1, 1'b0);
    step(); chk_out("to.c3", 8'h80, 3'd7, 1'b1, 1'b0);
    step(); chk_out("to.c4", 8'h80, 3'd7, 1'b1, 1'b0);
    step(); chk_out("to.pulse", 8'h00, 3'd7, 1'b0, 1'b1);
    step(); chk_out("to.regrant", 8'h80, 3'd7, 1'b1, 1'b0);
    // A new request from 0 does not preempt 7.
    req = 8'h81;
    step(); chk_out("nopreempt", 8'h80, 3'd7, 1'b1, 1'b0);
    rel = 1'b1;
    step(); chk_out("r7.exit", 8'h00, 3'd7, 1'b0, 1'b0);
    rel = 1'b0;
    step(); chk_out("wrap.g0", 8'h01, 3'd0, 1'b1, 1'b0);

    // Requester 2 withdraws; the next grant is the lowest set index at or after 3.
    rel = 1'b1;
    step(); chk_out("r0.exit", 8'h00, 3'd0, 1'b0, 1'b0);
    rel = 1'b0;
    req = 8'b0110_1100;
    step(); chk_out("g2", 8'h04, 3'd2, 1'b1, 1'b0);
    req = 8'b0110_1010;
    step(); chk_out("wd.exit", 8'h00, 3'd2, 1'b0, 1'b0);
    step(); chk_out("g3", 8'h08, 3'd3, 1'b1, 1'b0);

    // Release arrives on the same edge as the hold limit: normal exit, no timeout.
    step(); chk_out("g3.c2", 8'h08, 3'd3, 1'b1, 1'b0);
    step(); chk_out("g3.c3", 8'h08, 3'd3, 1'b1, 1'b0);
    step(); chk_out("g3.c4", 8'h08, 3'd3, 1'b1, 1'b0);
    rel = 1'b1;
    step(); chk_out("rel_lim.exit", 8'h00, 3'd3, 1'b0, 1'b0);
    rel = 1'b0;
    step(); chk_out("g5", 8'h20, 3'd5, 1'b1, 1'b0);

    // Withdrawal on the same edge as the hold limit: normal exit, no timeout.
    step(); chk_out("g5.c2", 8'h20, 3'd5, 1'b1, 1'b0);
    step(); chk_out("g5.c3", 8'h20, 3'd5, 1'b1, 1'b0);
    step(); chk_out("g5.c4", 8'h20, 3'd5, 1'b1, 1'b0);
    req = 8'b0100_1010;
    step(); chk_out("wd_lim.exit", 8'h00, 3'd5, 1'b0, 1'b0);
    step(); chk_out("g6", 8'h40, 3'd6, 1'b1, 1'b0);

    // Reset during a grant drops it at once; the first grant afterwards uses ptr=0.
    req = 8'hFF;
    step(); chk_out("g6.c2", 8'h40, 3'd6, 1'b1, 1'b0);
    rst = 1'b1;
    step(); chk_out("rst.mid", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step(); chk_out("post_rst", 8'h01, 3'd0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameter MAX_HOLD, default 15, maximum consecutive grant cycles before forced release; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  8  request vector; bit i = requester i wants the shared resource.
REQ-005 release  input  1  current grant holder finished; sampled only in GRANT.
REQ-006 gnt  output  8  registered one-hot grant vector, or all-zero when no grant.
REQ-007 gnt_idx  output  3  registered binary index of granted requester, i.e. the 8-to-3 encoding of gnt.
REQ-008 gnt_valid  output  1  registered; high exactly when gnt is non-zero.
REQ-009 timeout  output  1  registered one-cycle pulse on forced release.

Function
REQ-010 The FSM SHALL have two states: IDLE and GRANT.
REQ-011 In IDLE with req==0, the block SHALL stay in IDLE with gnt=0, gnt_valid=0, and gnt_idx holding its last value.
REQ-012 In IDLE with req!=0, the block SHALL pick the first set bit scanning ptr, ptr+1, ... ptr+7 (mod 8), then enter GRANT on the same edge.
REQ-013 The grant latency SHALL be one cycle: req sampled at edge k gives gnt, gnt_idx and gnt_valid valid after edge k.
REQ-014 gnt SHALL always be strictly one-hot or zero, and gnt_idx SHALL equal the position of the set bit whenever gnt_valid=1.
REQ-015 In GRANT, a 8-bit hold counter SHALL clear on entry and increment once per cycle spent in GRANT.
REQ-016 GRANT SHALL exit to IDLE on the first edge where any of these holds: release=1; req[gnt_idx]=0 (requester withdrew); hold counter == MAX_HOLD-1.
REQ-017 On GRANT exit, the block SHALL set ptr to gnt_idx+1 mod 8 (so index 7 wraps to 0) and clear gnt and gnt_valid.
REQ-018 After every grant, the block SHALL spend at least one IDLE cycle with gnt=0 (dead cycle); back-to-back grants SHALL therefore be 1 cycle apart at minimum.
REQ-019 timeout SHALL pulse high for exactly the one cycle following an exit caused only by the hold limit.
REQ-020 If release=1 or a withdrawn request coincides with the hold limit, the exit SHALL count as normal and timeout SHALL stay 0.
REQ-021 In GRANT, changes on req bits other than gnt_idx SHALL be ignored; no preemption.
REQ-022 With MAX_HOLD=1, every grant SHALL last exactly one cycle, and timeout SHALL pulse unless release or withdrawal occurs in that cycle.
REQ-023 A requester whose bit stays continuously set SHALL be granted within 8 grant periods (starvation-free).

Reset
REQ-024 With rst=1 at a rising edge: state=IDLE, ptr=0, hold counter=0, gnt=8'h00, gnt_idx=3'b000, gnt_valid=0, timeout=0.
REQ-025 Reset SHALL take priority over all other inputs, and reset during GRANT SHALL drop the grant on that edge without a timeout pulse.
REQ-026 req sampled in the first cycle after rst falls SHALL be arbitrated with ptr=0.

Verification
REQ-027 After reset, req=8'b00010000 then release after 3 cycles -> gnt=8'b00010000, gnt_idx=3'b100 for 3 cycles, then 1 cycle of gnt=0, ptr=5.
REQ-028 From ptr=0, req=8'hFF held constant with release pulsed each grant cycle -> gnt_idx sequence 0,1,2,...,7,0, with gnt=0 between grants.
REQ-029 MAX_HOLD=4, req=8'b10000000 held, release=0 -> gnt_idx=3'b111 for 4 cycles, then timeout=1 for one cycle, then regrant of index 7 after the dead cycle, ptr having wrapped to 0.
REQ-030 While requester 2 is granted, drop req[2] -> exit on that edge, timeout=0, next grant goes to the lowest set index at or after 3.
REQ-031 rst=1 asserted mid-GRANT with req=8'hFF -> on that edge gnt=0, gnt_valid=0, timeout=0; after rst falls the first grant is index 0.
REQ-032 release=1 on the same edge the hold counter hits MAX_HOLD-1 -> normal exit, timeout stays 0.
